// File: rtl/fht_pkg.sv
// Shared types and address arithmetic for the radix-2 FHT sequencer.
// Addresses are computed in 32 bits; callers truncate to A_BIT bits, which gives the mod-N wrap.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    localparam int RD_LAT_DEF  = 1;
    localparam int BUT_LAT_DEF = 2;

    function automatic int fht_pipe_lat(input int rd_lat, input int but_lat);
        return rd_lat + but_lat;
    endfunction

    localparam int PIPE_LAT_DEF = fht_pipe_lat(RD_LAT_DEF, BUT_LAT_DEF);

    function automatic int unsigned fht_k(input int unsigned b, input int unsigned s);
        return b & ((32'd1 << s) - 32'd1);
    endfunction

    function automatic int unsigned fht_base(input int unsigned b, input int unsigned s);
        return (b >> s) << (s + 32'd1);
    endfunction

    function automatic int unsigned fht_addr0(input int unsigned b, input int unsigned s);
        return fht_base(b, s) + fht_k(b, s);
    endfunction

    function automatic int unsigned fht_addr1(input int unsigned b, input int unsigned s);
        return fht_addr0(b, s) + (32'd1 << s);
    endfunction

    // Cross term pairs k with H-k inside the same group; k=0 maps onto itself.
    function automatic int unsigned fht_addr2(input int unsigned b, input int unsigned s);
        int unsigned h;
        h = 32'd1 << s;
        return fht_base(b, s) + h + ((h - fht_k(b, s)) & (h - 32'd1));
    endfunction

    function automatic int unsigned fht_tw(input int unsigned b, input int unsigned s,
                                           input int unsigned a_bit);
        return fht_k(b, s) << (a_bit - 32'd1 - s);
    endfunction

endpackage

// File: rtl/fht_dly_line.sv
// Fixed-depth shift register with synchronous clear, used to align addresses and strobes
// with the RAM/butterfly pipeline.
module fht_dly_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] pipe_d [DEPTH];
    logic [WIDTH-1:0] pipe_q [DEPTH];

    // Next-state of each tap: tap 0 takes the input, later taps take their predecessor.
    always_comb begin
        pipe_d[0] = iD;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Tap registers, cleared by reset so nothing in flight survives an abort.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign oQ = pipe_q[DEPTH-1];

endmodule

// File: rtl/fht_ctrl.sv
// Radix-2 FHT sequencer: one butterfly per clock over ping-pong banks, with
// read addresses, twiddle index and pipeline-delayed write-back addresses.
module fht_ctrl
    import fht_pkg::*;
#(
    parameter int A_BIT   = 4,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int BUT_LAT = BUT_LAT_DEF,
    localparam int STG_W  = (A_BIT > 1) ? $clog2(A_BIT) : 1
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [STG_W-1:0] oSTAGE,
    output logic             oBANK,
    output logic [A_BIT-1:0] oRD_ADDR_0,
    output logic [A_BIT-1:0] oRD_ADDR_1,
    output logic [A_BIT-1:0] oRD_ADDR_2,
    output logic             oRD_EN,
    output logic [A_BIT-2:0] oTW_ADDR,
    output logic [A_BIT-1:0] oWR_ADDR_0,
    output logic [A_BIT-1:0] oWR_ADDR_1,
    output logic             oWR_EN,
    output logic             oRES_BANK
);

    localparam int BW   = A_BIT - 1;
    localparam int TW_W = A_BIT - 1;
    localparam int LAT  = fht_pipe_lat(RD_LAT, BUT_LAT);
    localparam int FW   = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [BW-1:0]    B_LAST = {BW{1'b1}};
    localparam logic [STG_W-1:0] S_LAST = STG_W'(A_BIT - 1);
    localparam logic [FW-1:0]    F_LAST = FW'(LAT - 1);

    fht_state_e       state_d, state_q;
    logic [BW-1:0]    b_d, b_q;
    logic [STG_W-1:0] stage_d, stage_q;
    logic [FW-1:0]    fcnt_d, fcnt_q;
    logic             bank_d, bank_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             res_bank_d, res_bank_q;
    logic             rd_en_d, rd_en_q;
    logic [A_BIT-1:0] addr0_d, addr0_q;
    logic [A_BIT-1:0] rd_addr_1_d, rd_addr_1_q;
    logic [A_BIT-1:0] rd_addr_2_d, rd_addr_2_q;
    logic [TW_W-1:0]  tw_addr_d, tw_addr_q;
    logic [2*A_BIT:0] wb_s;

    // Sequencing and per-butterfly address generation for the cycle after this edge.
    always_comb begin
        state_d    = state_q;
        b_d        = b_q;
        stage_d    = stage_q;
        fcnt_d     = fcnt_q;
        bank_d     = bank_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        res_bank_d = res_bank_q;
        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    state_d = ST_RUN;
                    b_d     = '0;
                    stage_d = '0;
                    bank_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (b_q == B_LAST) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                end else begin
                    b_d = b_q + BW'(1);
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == F_LAST) begin
                    if (stage_q == S_LAST) begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        res_bank_d = ~bank_q;
                    end else begin
                        state_d = ST_RUN;
                        stage_d = stage_q + STG_W'(1);
                        bank_d  = ~bank_q;
                        b_d     = '0;
                    end
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = '0;
                bank_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                stage_d = '0;
                bank_d  = 1'b0;
                busy_d  = 1'b0;
            end
        endcase

        if (state_d == ST_RUN) begin
            rd_en_d     = 1'b1;
            addr0_d     = A_BIT'(fht_addr0(32'(b_d), 32'(stage_d)));
            rd_addr_1_d = A_BIT'(fht_addr1(32'(b_d), 32'(stage_d)));
            rd_addr_2_d = A_BIT'(fht_addr2(32'(b_d), 32'(stage_d)));
            tw_addr_d   = TW_W'(fht_tw(32'(b_d), 32'(stage_d), 32'(A_BIT)));
        end else begin
            rd_en_d     = 1'b0;
            addr0_d     = '0;
            rd_addr_1_d = '0;
            rd_addr_2_d = '0;
            tw_addr_d   = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q     <= ST_IDLE;
            b_q         <= '0;
            stage_q     <= '0;
            fcnt_q      <= '0;
            bank_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_bank_q  <= 1'b0;
            rd_en_q     <= 1'b0;
            addr0_q     <= '0;
            rd_addr_1_q <= '0;
            rd_addr_2_q <= '0;
            tw_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            stage_q     <= stage_d;
            fcnt_q      <= fcnt_d;
            bank_q      <= bank_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_bank_q  <= res_bank_d;
            rd_en_q     <= rd_en_d;
            addr0_q     <= addr0_d;
            rd_addr_1_q <= rd_addr_1_d;
            rd_addr_2_q <= rd_addr_2_d;
            tw_addr_q   <= tw_addr_d;
        end
    end

    // X0 is consumed alongside the registered product term, one cycle behind X1/X2.
    fht_dly_line #(
        .WIDTH (A_BIT),
        .DEPTH (1)
    ) u_a0_dly (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iD     (addr0_q),
        .oQ     (oRD_ADDR_0)
    );

    fht_dly_line #(
        .WIDTH (2*A_BIT + 1),
        .DEPTH (LAT)
    ) u_wb_dly (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iD     ({addr0_q, rd_addr_1_q, rd_en_q}),
        .oQ     (wb_s)
    );

    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oSTAGE     = stage_q;
    assign oBANK      = bank_q;
    assign oRD_ADDR_1 = rd_addr_1_q;
    assign oRD_ADDR_2 = rd_addr_2_q;
    assign oRD_EN     = rd_en_q;
    assign oTW_ADDR   = tw_addr_q;
    assign oRES_BANK  = res_bank_q;
    assign oWR_ADDR_0 = wb_s[2*A_BIT:A_BIT+1];
    assign oWR_ADDR_1 = wb_s[A_BIT:1];
    assign oWR_EN     = wb_s[0];

endmodule

// File: tb/tb_fht_ctrl.sv
// Self-checking bench for fht_ctrl: a cycle-indexed expectation table built from
// group/offset loops, plus a per-stage write-coverage scoreboard.
module tb_fht_ctrl;

    localparam int A_BIT     = 4;
    localparam int RD_LAT    = 1;
    localparam int BUT_LAT   = 2;
    localparam int N         = 16;
    localparam int HALF      = N / 2;
    localparam int LAT       = RD_LAT + BUT_LAT;
    localparam int STAGE_CYC = HALF + LAT;
    localparam int TOTAL     = A_BIT * STAGE_CYC;
    localparam int SPAN      = TOTAL + 4;

    logic             iCLK = 1'b0;
    logic             iRESET;
    logic             iSTART;
    logic             oBUSY, oDONE, oBANK, oRD_EN, oWR_EN, oRES_BANK;
    logic [1:0]       oSTAGE;
    logic [A_BIT-1:0] oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oWR_ADDR_0, oWR_ADDR_1;
    logic [A_BIT-2:0] oTW_ADDR;

    fht_ctrl #(.A_BIT(A_BIT), .RD_LAT(RD_LAT), .BUT_LAT(BUT_LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART),
        .oBUSY(oBUSY), .oDONE(oDONE), .oSTAGE(oSTAGE), .oBANK(oBANK),
        .oRD_ADDR_0(oRD_ADDR_0), .oRD_ADDR_1(oRD_ADDR_1), .oRD_ADDR_2(oRD_ADDR_2),
        .oRD_EN(oRD_EN), .oTW_ADDR(oTW_ADDR),
        .oWR_ADDR_0(oWR_ADDR_0), .oWR_ADDR_1(oWR_ADDR_1), .oWR_EN(oWR_EN),
        .oRES_BANK(oRES_BANK)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;

    bit m_rd [SPAN];
    bit m_a0v[SPAN];
    bit m_wr [SPAN];
    int m_a0 [SPAN];
    int m_a1 [SPAN];
    int m_a2 [SPAN];
    int m_tw [SPAN];
    int m_stg[SPAN];
    int m_w0 [SPAN];
    int m_w1 [SPAN];
    int m_done_cyc;
    int seen [A_BIT][N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected schedule: stages back to back, each butterfly (group g, offset k) in order,
    // then LAT idle cycles so the last write lands before the next stage reads.
    task automatic build_model();
        int cyc, h, a0;
        for (int i = 0; i < SPAN; i++) begin
            m_rd[i] = 0; m_a0v[i] = 0; m_wr[i] = 0;
        end
        cyc = 0;
        for (int s = 0; s < A_BIT; s++) begin
            h = 2 ** s;
            for (int g = 0; g < N / (2 * h); g++) begin
                for (int k = 0; k < h; k++) begin
                    a0 = g * 2 * h + k;
                    m_rd[cyc]  = 1;
                    m_a1[cyc]  = (a0 + h) % N;
                    m_a2[cyc]  = (g * 2 * h + h + ((h - k) % h)) % N;
                    m_tw[cyc]  = k * HALF / h;
                    m_stg[cyc] = s;
                    m_a0v[cyc + 1] = 1;
                    m_a0[cyc + 1]  = a0;
                    m_wr[cyc + LAT] = 1;
                    m_w0[cyc + LAT] = a0;
                    m_w1[cyc + LAT] = (a0 + h) % N;
                    cyc++;
                end
            end
            cyc += LAT;
        end
        m_done_cyc = cyc;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, " busy"}, oBUSY, 0);
        chk({tag, " done"}, oDONE, 0);
        chk({tag, " stage"}, oSTAGE, 0);
        chk({tag, " bank"}, oBANK, 0);
        chk({tag, " rd_en"}, oRD_EN, 0);
        chk({tag, " wr_en"}, oWR_EN, 0);
        chk({tag, " rd_a0"}, oRD_ADDR_0, 0);
        chk({tag, " rd_a1"}, oRD_ADDR_1, 0);
        chk({tag, " rd_a2"}, oRD_ADDR_2, 0);
        chk({tag, " tw"}, oTW_ADDR, 0);
        chk({tag, " wr_a0"}, oWR_ADDR_0, 0);
        chk({tag, " wr_a1"}, oWR_ADDR_1, 0);
        chk({tag, " res_bank"}, oRES_BANK, 0);
    endtask

    task automatic check_cycle(input string tag, input int c);
        string t;
        t = $sformatf("%s c%0d", tag, c);
        chk({t, " rd_en"}, oRD_EN, m_rd[c]);
        chk({t, " wr_en"}, oWR_EN, m_wr[c]);
        chk({t, " done"}, oDONE, (c == m_done_cyc));
        chk({t, " busy"}, oBUSY, (c < m_done_cyc));
        if (m_rd[c]) begin
            chk({t, " rd_a1"}, oRD_ADDR_1, m_a1[c]);
            chk({t, " rd_a2"}, oRD_ADDR_2, m_a2[c]);
            chk({t, " tw"}, oTW_ADDR, m_tw[c]);
            chk({t, " stage"}, oSTAGE, m_stg[c]);
            chk({t, " bank"}, oBANK, m_stg[c] % 2);
        end
        if (m_a0v[c]) chk({t, " rd_a0"}, oRD_ADDR_0, m_a0[c]);
        if (m_wr[c]) begin
            chk({t, " wr_a0"}, oWR_ADDR_0, m_w0[c]);
            chk({t, " wr_a1"}, oWR_ADDR_1, m_w1[c]);
        end
        if (c == m_done_cyc) chk({t, " res_bank"}, oRES_BANK, A_BIT % 2);
        if (oWR_EN === 1'b1 && c < TOTAL) begin
            seen[c / STAGE_CYC][oWR_ADDR_0]++;
            seen[c / STAGE_CYC][oWR_ADDR_1]++;
        end
    endtask

    // One transform from a start pulse; iSTART stays high for `hold` extra cycles,
    // and abort_at >= 0 asserts reset after that cycle's checks.
    task automatic run_xform(input string tag, input int hold, input int abort_at);
        int once;
        for (int s = 0; s < A_BIT; s++)
            for (int a = 0; a < N; a++) seen[s][a] = 0;
        iSTART = 1'b1;
        @(posedge iCLK);
        for (int c = 0; c < SPAN; c++) begin
            @(negedge iCLK);
            if (c >= hold) iSTART = 1'b0;
            check_cycle(tag, c);
            if (c == abort_at) begin
                iRESET = 1'b1;
                iSTART = 1'b0;
                @(negedge iCLK);
                check_quiet({tag, " abort"});
                iRESET = 1'b0;
                for (int j = 0; j < 12; j++) begin
                    @(negedge iCLK);
                    chk($sformatf("%s post-abort %0d wr_en", tag, j), oWR_EN, 0);
                    chk($sformatf("%s post-abort %0d done", tag, j), oDONE, 0);
                    chk($sformatf("%s post-abort %0d busy", tag, j), oBUSY, 0);
                end
                return;
            end
        end
        iSTART = 1'b0;
        for (int s = 0; s < A_BIT; s++) begin
            once = 0;
            for (int a = 0; a < N; a++) if (seen[s][a] == 1) once++;
            chk($sformatf("%s stage%0d written-once", tag, s), once, N);
        end
    endtask

    initial begin
        int gap;
        build_model();
        iRESET = 1'b1;
        iSTART = 1'b0;
        repeat (3) @(negedge iCLK);
        check_quiet("reset");
        iRESET = 1'b0;
        @(negedge iCLK);
        check_quiet("idle");

        run_xform("run1", 0, -1);
        gap = $urandom_range(1, 6);
        repeat (gap) @(negedge iCLK);
        run_xform("hold", $urandom_range(2, 30), -1);
        repeat ($urandom_range(1, 6)) @(negedge iCLK);
        run_xform("rerun", 0, -1);
        repeat (2) @(negedge iCLK);
        run_xform("abort20", 0, 20);
        run_xform("after_abort", 0, -1);
        repeat ($urandom_range(1, 6)) @(negedge iCLK);
        run_xform("abort_rand", $urandom_range(0, 3), $urandom_range(1, TOTAL - 1));
        run_xform("final", 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
